dist_filter_apb: RTL and testbench

Downstream consumer of the distance-sensor pulse-count stage. Takes each new 32-bit distance sample, smooths it with a 4-tap running average, and runs a near/far hysteresis state machine. Flags obstacles to the processor through a level output and a maskable interrupt. APB3 slave on the same bus as the sensor block; thresholds and status are software-visible.

---
 rtl/dist_filter_apb.sv | 167 ++++++++++++++++
 tb/tb_dist_filter_apb.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dist_filter_apb.sv
`default_nettype none
// ============================================================================
// Module   : dist_filter_apb
// Function : Distance-sample filter with a near/far hysteresis FSM, obstacle
//            flag and maskable interrupt behind an APB3 slave. Optional macro
//            DIST_FILTER_AVG_EN selects the 4-tap running average; otherwise
//            FILTERED is the last accepted sample.
// Revision : 1.0 - initial release
// ============================================================================
module dist_filter_apb #(
   parameter logic [31:0] NEAR_DEFAULT = 32'd15000,
   parameter logic [31:0] FAR_DEFAULT  = 32'd20000
) (
   input  logic        PCLK,
   input  logic        PRESERN,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   input  logic [31:0] dist_in,
   input  logic        dist_valid,
   output logic        obstacle,
   output logic        irq
);

   localparam logic [0:0] C_ST_CLEAR = 1'b0;
   localparam logic [0:0] C_ST_NEAR  = 1'b1;

   localparam logic [7:0] C_A_CTRL   = 8'h00;
   localparam logic [7:0] C_A_NEAR   = 8'h04;
   localparam logic [7:0] C_A_FAR    = 8'h08;
   localparam logic [7:0] C_A_FILT   = 8'h0C;
   localparam logic [7:0] C_A_STATUS = 8'h10;

`ifdef DIST_FILTER_AVG_EN
   localparam logic [2:0] C_FILL_MAX = 3'd4;
`else
   localparam logic [2:0] C_FILL_MAX = 3'd1;
`endif

   logic        en_q, irq_en_q, eval_q, irq_pend_q, irq_pend_d;
   logic [31:0] thr_near_q, thr_far_q;
   logic [2:0]  fill_q;
   logic [0:0]  state_q, state_d;
   logic [31:0] w_filtered;
   logic        w_win_full, w_wr, w_accept, w_disable;
   logic [7:0]  w_addr;
   logic        w_unused;

   assign w_addr    = PADDR[7:0];
   assign w_unused  = &{1'b0, PADDR[31:8]};
   assign w_wr      = PSEL & PENABLE & PWRITE;
   assign w_accept  = dist_valid & en_q;
   // Only a 1->0 transition of enable flushes the filter and FSM.
   assign w_disable = w_wr && (w_addr == C_A_CTRL) && !PWDATA[0] && en_q;
   assign w_win_full = (fill_q == C_FILL_MAX);

`ifdef DIST_FILTER_AVG_EN
   logic [3:0][31:0] win_q;
   logic [33:0]      sum_q;

   always_ff @(posedge PCLK) begin
      if (!PRESERN || w_disable) begin
         win_q <= '0;
         sum_q <= '0;
      end else if (w_accept) begin
         sum_q <= sum_q + {2'b00, dist_in} - {2'b00, win_q[3]};
         win_q <= {win_q[2:0], dist_in};
      end
   end

   assign w_filtered = sum_q[33:2];
`else
   logic [31:0] last_q;

   always_ff @(posedge PCLK) begin
      if (!PRESERN || w_disable) begin
         last_q <= '0;
      end else if (w_accept) begin
         last_q <= dist_in;
      end
   end

   assign w_filtered = last_q;
`endif

   // eval_q marks the cycle after an accepted sample, when FILTERED is fresh.
   always_comb begin
      state_d = state_q;
      if (eval_q && w_win_full) begin
         if (state_q == C_ST_CLEAR && w_filtered < thr_near_q) begin
            state_d = C_ST_NEAR;
         end else if (state_q == C_ST_NEAR && w_filtered > thr_far_q) begin
            state_d = C_ST_CLEAR;
         end
      end
      irq_pend_d = irq_pend_q;
      if (w_wr && w_addr == C_A_STATUS && PWDATA[1]) begin
         irq_pend_d = 1'b0;
      end
      if (state_d != state_q) begin
         irq_pend_d = 1'b1;
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESERN) begin
         en_q       <= 1'b0;
         irq_en_q   <= 1'b0;
         thr_near_q <= NEAR_DEFAULT;
         thr_far_q  <= FAR_DEFAULT;
         fill_q     <= 3'd0;
         state_q    <= C_ST_CLEAR;
         eval_q     <= 1'b0;
         irq_pend_q <= 1'b0;
      end else begin
         if (w_wr && w_addr == C_A_CTRL) begin
            en_q     <= PWDATA[0];
            irq_en_q <= PWDATA[1];
         end
         if (w_wr && w_addr == C_A_NEAR) begin
            thr_near_q <= PWDATA;
         end
         if (w_wr && w_addr == C_A_FAR) begin
            thr_far_q <= PWDATA;
         end
         irq_pend_q <= irq_pend_d;
         if (w_disable) begin
            fill_q  <= 3'd0;
            state_q <= C_ST_CLEAR;
            eval_q  <= 1'b0;
         end else begin
            eval_q  <= w_accept;
            state_q <= state_d;
            if (w_accept && fill_q != C_FILL_MAX) begin
               fill_q <= fill_q + 3'd1;
            end
         end
      end
   end

   assign obstacle = (state_q == C_ST_NEAR);
   assign irq      = irq_pend_q & irq_en_q;
   assign PREADY   = 1'b1;
   assign PSLVERR  = 1'b0;

   // STATUS fill field is 2 bits wide; a full 4-deep window reads 0 there.
   always_comb begin
      PRDATA = 32'd0;
      if (PSEL) begin
         case (w_addr)
            C_A_CTRL:   PRDATA = {30'd0, irq_en_q, en_q};
            C_A_NEAR:   PRDATA = thr_near_q;
            C_A_FAR:    PRDATA = thr_far_q;
            C_A_FILT:   PRDATA = w_filtered;
            C_A_STATUS: PRDATA = {27'd0, fill_q[1:0], w_win_full, irq_pend_q, obstacle};
            default:    PRDATA = 32'd0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dist_filter_apb.sv
`default_nettype none
// ============================================================================
// Module   : tb_dist_filter_apb
// Function : Self-checking bench for dist_filter_apb with a filtered-value
//            scoreboard and a behavioural filter/FSM reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dist_filter_apb;

   logic        PCLK = 1'b0, PRESERN = 1'b0;
   logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [31:0] PADDR = '0, PWDATA = '0, PRDATA;
   logic        PREADY, PSLVERR;
   logic [31:0] dist_in = '0;
   logic        dist_valid = 1'b0;
   logic        obstacle, irq;

   int errors = 0;
   int checks = 0;

`ifdef DIST_FILTER_AVG_EN
   localparam int DEPTH = 4;
   logic [31:0] fill_exp [4] = '{32'd25, 32'd75, 32'd150, 32'd250};
   logic [31:0] refill_last = 32'd2500;
`else
   localparam int DEPTH = 1;
   logic [31:0] fill_exp [4] = '{32'd100, 32'd200, 32'd300, 32'd400};
   logic [31:0] refill_last = 32'd4000;
`endif

   dist_filter_apb dut (
      .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .dist_in(dist_in),
      .dist_valid(dist_valid), .obstacle(obstacle), .irq(irq)
   );

   always #5 PCLK = ~PCLK;

   // Reference model state
   logic [31:0] hist [$];
   logic [31:0] stim_q [$];
   logic [31:0] exp_q [$];
   logic        m_en, m_irqen, m_near, m_pend;
   logic [31:0] m_tn, m_tf;

   function automatic void m_reset();
      hist.delete();
      m_en = 1'b0; m_irqen = 1'b0; m_near = 1'b0; m_pend = 1'b0;
      m_tn = 32'd15000; m_tf = 32'd20000;
   endfunction

   function automatic logic [31:0] m_filtered();
      logic [33:0] s;
      s = '0;
      foreach (hist[i]) s = s + {2'b00, hist[i]};
      return (DEPTH == 4) ? s[33:2] : s[31:0];
   endfunction

   function automatic logic [31:0] m_status();
      logic [2:0] sz;
      sz = 3'(hist.size());
      return {27'd0, sz[1:0], (hist.size() == DEPTH), m_pend, m_near};
   endfunction

   function automatic void m_accept(input logic [31:0] d);
      logic [31:0] f;
      if (!m_en) return;
      hist.push_back(d);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      if (hist.size() == DEPTH) begin
         f = m_filtered();
         if (!m_near && f < m_tn) begin m_near = 1'b1; m_pend = 1'b1; end
         else if (m_near && f > m_tf) begin m_near = 1'b0; m_pend = 1'b1; end
      end
   endfunction

   task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = {24'd0, a}; PWDATA = d;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      if (a == 8'h00) begin
         if (m_en && !d[0]) begin hist.delete(); m_near = 1'b0; end
         m_en = d[0]; m_irqen = d[1];
      end
      if (a == 8'h04) m_tn = d;
      if (a == 8'h08) m_tf = d;
      if (a == 8'h10 && d[1]) m_pend = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = {24'd0, a};
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      #1 d = PRDATA;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   // One strobe, FILTERED checked at N+1, obstacle/irq checked at N+1 and N+2.
   task automatic send_one(input logic [31:0] d);
      logic        prev_obs, prev_irq;
      logic [31:0] e;
      prev_obs = m_near; prev_irq = m_pend & m_irqen;
      @(posedge PCLK); #1;
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 32'h0C;
      dist_in = d; dist_valid = 1'b1;
      m_accept(d);
      exp_q.push_back(m_filtered());
      @(posedge PCLK); #1;
      dist_valid = 1'b0;
      e = exp_q.pop_front();
      checks++; if (PRDATA !== e) begin errors++; $display("FAIL filtered_n1: got %h expected %h", PRDATA, e); end
      checks++; if (obstacle !== prev_obs) begin errors++; $display("FAIL obstacle_n1: got %b expected %b", obstacle, prev_obs); end
      checks++; if (irq !== prev_irq) begin errors++; $display("FAIL irq_n1: got %b expected %b", irq, prev_irq); end
      @(posedge PCLK); #1;
      checks++; if (obstacle !== m_near) begin errors++; $display("FAIL obstacle_n2: got %b expected %b", obstacle, m_near); end
      checks++; if (irq !== (m_pend & m_irqen)) begin errors++; $display("FAIL irq_n2: got %b expected %b", irq, m_pend & m_irqen); end
      PSEL = 1'b0;
   endtask

   // Back-to-back strobes from stim_q; FILTERED compared every cycle.
   task automatic stream();
      logic [31:0] d, e;
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 32'h0C;
      while (stim_q.size() > 0 || exp_q.size() > 0) begin
         @(posedge PCLK); #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (PRDATA !== e) begin errors++; $display("FAIL stream_filtered: got %h expected %h", PRDATA, e); end
         end
         if (stim_q.size() > 0) begin
            d = stim_q.pop_front();
            dist_in = d; dist_valid = 1'b1;
            m_accept(d);
            exp_q.push_back(m_filtered());
         end else begin
            dist_valid = 1'b0;
         end
      end
      dist_valid = 1'b0; PSEL = 1'b0;
      @(posedge PCLK); #1;
      checks++; if (obstacle !== m_near) begin errors++; $display("FAIL stream_obstacle: got %b expected %b", obstacle, m_near); end
      checks++; if (irq !== (m_pend & m_irqen)) begin errors++; $display("FAIL stream_irq: got %b expected %b", irq, m_pend & m_irqen); end
   endtask

   task automatic test_reset();
      logic [31:0] r;
      checks++; if (obstacle !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL reset_outputs: got %b%b expected 00", obstacle, irq); end
      checks++; if (PREADY !== 1'b1 || PSLVERR !== 1'b0) begin errors++; $display("FAIL ready_slverr: got %b%b expected 10", PREADY, PSLVERR); end
      apb_read(8'h00, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got %h expected %h", r, 32'd0); end
      apb_read(8'h04, r);
      checks++; if (r !== 32'd15000) begin errors++; $display("FAIL reset_near: got %h expected %h", r, 32'd15000); end
      apb_read(8'h08, r);
      checks++; if (r !== 32'd20000) begin errors++; $display("FAIL reset_far: got %h expected %h", r, 32'd20000); end
      apb_read(8'h0C, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_filtered: got %h expected %h", r, 32'd0); end
      apb_read(8'h10, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_status: got %h expected %h", r, 32'd0); end
      checks++; if (PRDATA !== 32'd0) begin errors++; $display("FAIL prdata_idle: got %h expected %h", PRDATA, 32'd0); end
   endtask

   task automatic test_regs();
      logic [31:0] r;
      apb_write(8'h04, 32'h0001_2345);
      apb_read(8'h04, r);
      checks++; if (r !== 32'h0001_2345) begin errors++; $display("FAIL near_rw: got %h expected %h", r, 32'h0001_2345); end
      apb_write(8'h08, 32'hABCD_0000);
      apb_read(8'h08, r);
      checks++; if (r !== 32'hABCD_0000) begin errors++; $display("FAIL far_rw: got %h expected %h", r, 32'hABCD_0000); end
      apb_write(8'h14, 32'hFFFF_FFFF);
      apb_read(8'h14, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL unmapped: got %h expected %h", r, 32'd0); end
      apb_write(8'h04, 32'd15000);
      apb_write(8'h08, 32'd20000);
   endtask

   task automatic test_fill();
      logic [31:0] r;
      apb_write(8'h00, 32'h1);
      for (int i = 0; i < 4; i++) begin
         send_one(32'(100 * (i + 1)));
         apb_read(8'h0C, r);
         checks++; if (r !== fill_exp[i]) begin errors++; $display("FAIL fill_filtered%0d: got %h expected %h", i, r, fill_exp[i]); end
         apb_read(8'h10, r);
         checks++; if (r !== m_status()) begin errors++; $display("FAIL fill_status%0d: got %h expected %h", i, r, m_status()); end
         checks++; if (r[2] !== (i >= DEPTH - 1)) begin errors++; $display("FAIL fill_winfull%0d: got %b expected %b", i, r[2], i >= DEPTH - 1); end
      end
      apb_write(8'h00, 32'h0);
      apb_write(8'h10, 32'h2);
   endtask

   task automatic test_near_irq();
      logic [31:0] r;
      apb_write(8'h00, 32'h3);
      for (int i = 0; i < 4; i++) send_one(32'd10000);
      checks++; if (obstacle !== 1'b1 || irq !== 1'b1) begin errors++; $display("FAIL near_set: got %b%b expected 11", obstacle, irq); end
      apb_write(8'h10, 32'h2);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b expected %b", irq, 1'b0); end
      apb_read(8'h10, r);
      checks++; if (r !== m_status()) begin errors++; $display("FAIL w1c_status: got %h expected %h", r, m_status()); end
   endtask

   task automatic test_hysteresis();
      logic [31:0] r;
      for (int i = 0; i < 4; i++) send_one(32'd18000);
      checks++; if (obstacle !== 1'b1 || irq !== 1'b0) begin errors++; $display("FAIL hold_between: got %b%b expected 10", obstacle, irq); end
      for (int i = 0; i < 4; i++) send_one(32'd20000);
      checks++; if (obstacle !== 1'b1 || irq !== 1'b0) begin errors++; $display("FAIL hold_equal: got %b%b expected 10", obstacle, irq); end
      send_one(32'd25000);
      checks++; if (obstacle !== 1'b0 || irq !== 1'b1) begin errors++; $display("FAIL far_clear: got %b%b expected 01", obstacle, irq); end
      apb_read(8'h10, r);
      checks++; if (r !== m_status()) begin errors++; $display("FAIL far_status: got %h expected %h", r, m_status()); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r;
      apb_write(8'h10, 32'h2);
      for (int i = 0; i < 6; i++) stim_q.push_back(32'hFFFF_FFFF);
      stream();
      apb_read(8'h0C, r);
      checks++; if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL flood_filtered: got %h expected %h", r, 32'hFFFF_FFFF); end
      // Restart the window, then line a W1C up with a CLEAR->NEAR transition.
      apb_write(8'h00, 32'h0);
      apb_write(8'h00, 32'h3);
      for (int i = 0; i < DEPTH - 1; i++) stim_q.push_back(32'd5000);
      stream();
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'h2;
      dist_in = 32'd5000; dist_valid = 1'b1;
      m_accept(32'd5000);
      @(posedge PCLK); #1;
      dist_valid = 1'b0; PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      apb_read(8'h10, r);
      checks++; if (r[1] !== 1'b1) begin errors++; $display("FAIL set_wins_w1c: got %b expected %b", r[1], 1'b1); end
      checks++; if (r !== m_status()) begin errors++; $display("FAIL collide_status: got %h expected %h", r, m_status()); end
   endtask

   task automatic test_disable_mid();
      logic [31:0] r;
      stim_q.push_back(32'd7000);
      stim_q.push_back(32'd6000);
      stream();
      apb_write(8'h00, 32'h0);
      apb_read(8'h10, r);
      checks++; if (r !== 32'h2) begin errors++; $display("FAIL disable_status: got %h expected %h", r, 32'h2); end
      apb_read(8'h0C, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL disable_filtered: got %h expected %h", r, 32'd0); end
      send_one(32'd123);
      apb_write(8'h00, 32'h1);
      for (int i = 0; i < 4; i++) send_one(32'(1000 * (i + 1)));
      apb_read(8'h0C, r);
      checks++; if (r !== refill_last) begin errors++; $display("FAIL refill_filtered: got %h expected %h", r, refill_last); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      apb_write(8'h00, 32'h3);
      stim_q.push_back(32'd8000);
      stim_q.push_back(32'd9000);
      stream();
      @(posedge PCLK); #1 PRESERN = 1'b0;
      @(posedge PCLK); #1 PRESERN = 1'b1;
      m_reset();
      checks++; if (obstacle !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL rst_outputs: got %b%b expected 00", obstacle, irq); end
      apb_read(8'h10, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL rst_status: got %h expected %h", r, 32'd0); end
      apb_read(8'h00, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL rst_ctrl: got %h expected %h", r, 32'd0); end
      apb_read(8'h0C, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL rst_filtered: got %h expected %h", r, 32'd0); end
      apb_write(8'h00, 32'h1);
      for (int i = 0; i < 4; i++) send_one(32'(1000 * (i + 1)));
      apb_read(8'h10, r);
      checks++; if (r !== m_status()) begin errors++; $display("FAIL rst_refill_status: got %h expected %h", r, m_status()); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      m_reset();
      PRESERN = 1'b0;
      repeat (3) @(posedge PCLK);
      #1 PRESERN = 1'b1;
      test_reset();
      test_regs();
      test_fill();
      test_near_irq();
      test_hysteresis();
      test_back_to_back();
      test_disable_mid();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
